nvram_xfer: RTL and testbench

- Transfer engine on the far side of the 256x8 high-score NVRAM: streams NVRAM contents out to the HPS ioctl interface (save) and back in from it (load).
- Sits between the CPU's NVRAM bus and the nvram instance.
- Halts the CPU for the duration of a transfer and owns the NVRAM port while the CPU is halted; otherwise passes CPU accesses straight through.

---
 rtl/nvram_xfer_if.sv | 29 ++
 rtl/nvram_xfer.sv | 161 ++++++++++++++++
 tb/tb_nvram_xfer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvram_xfer_if.sv
// nvram_xfer_if: HPS ioctl bus between the HPS bridge and the NVRAM transfer engine.
//   master : HPS side. Drives the session flags, index, address, strobes and download data.
//   slave  : core side. Returns the upload data (ioctl_din) and the stall (ioctl_wait).
interface nvram_xfer_if;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 8;

  logic              ioctl_download;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic [ADDR_W-1:0] ioctl_addr;
  logic              ioctl_wr;
  logic [DATA_W-1:0] ioctl_dout;
  logic              ioctl_rd;
  logic [DATA_W-1:0] ioctl_din;
  logic              ioctl_wait;

  modport master (
    output ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
           ioctl_wr, ioctl_dout, ioctl_rd,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
           ioctl_wr, ioctl_dout, ioctl_rd,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/nvram_xfer.sv
// nvram_xfer: NVRAM save/load engine between the CPU, the 256x8 nvram and the HPS ioctl bus.
// The CPU is halted for a whole session. While it is halted, the engine owns the NVRAM port.
// Outside a session, CPU accesses pass straight through to the nvram.
// Ports:
//   clk, rst_n             : clock and synchronous active-low reset
//   ioctl (slave)          : HPS download/upload bus, including ioctl_din and ioctl_wait
//   cpu_halt_req/ack       : CPU halt handshake
//   cpu_nv_we/addr/din     : CPU NVRAM access. It is forwarded to nv_* outside a transfer.
//   nv_we/addr/din/dout    : nvram port. nv_dout has a 1-cycle registered read latency.
//   vblank                 : video vblank, used for the autosave quiet timer
//   busy, dirty, save_req  : status outputs
// Optional feature macro NVRAM_DIRTY_EN: dirty tracking and the vblank-timed autosave request.
module nvram_xfer #(
  parameter logic [7:0]  NV_INDEX        = 8'd4,
  parameter int unsigned AUTOSAVE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  nvram_xfer_if.slave ioctl,
  output logic       cpu_halt_req,
  input  logic       cpu_halt_ack,
  input  logic       cpu_nv_we,
  input  logic [7:0] cpu_nv_addr,
  input  logic [7:0] cpu_nv_din,
  output logic       nv_we,
  output logic [7:0] nv_addr,
  output logic [7:0] nv_din,
  input  logic [7:0] nv_dout,
  input  logic       vblank,
  output logic       busy,
  output logic       dirty,
  output logic       save_req
);
  typedef enum logic [2:0] {S_IDLE, S_HALT, S_XFER, S_RD1, S_RD2, S_REL} state_e;

  state_e     state_q, state_d;
  logic       halt_q, halt_d, wait_q, wait_d, busy_q, busy_d;
  logic [7:0] din_q, din_d, addr_q, addr_d, data_q, data_d;
  logic       oor_q, oor_d, wr_pend_q, wr_pend_d;
  logic       session_c, addr_oor_c, engine_sel_c;

  assign session_c  = (ioctl.ioctl_download | ioctl.ioctl_upload) & (ioctl.ioctl_index == NV_INDEX);
  assign addr_oor_c = |ioctl.ioctl_addr[24:8];

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      halt_q    <= 1'b0;
      wait_q    <= 1'b0;
      busy_q    <= 1'b0;
      din_q     <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      oor_q     <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      din_q     <= din_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      oor_q     <= oor_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // Next state and next outputs. The outputs are decoded from the next state, so they change on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    addr_d    = addr_q;
    data_d    = data_q;
    oor_d     = oor_q;
    wr_pend_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (session_c) state_d = S_HALT;
      S_HALT: if (cpu_halt_ack) state_d = S_XFER;
      S_XFER: begin
        // Download has priority when both flags are high.
        if (ioctl.ioctl_download) begin
          if (ioctl.ioctl_wr && !addr_oor_c) begin
            wr_pend_d = 1'b1;
            addr_d    = ioctl.ioctl_addr[7:0];
            data_d    = ioctl.ioctl_dout;
          end
        end else if (ioctl.ioctl_upload) begin
          if (ioctl.ioctl_rd) begin
            state_d = S_RD1;
            addr_d  = ioctl.ioctl_addr[7:0];
            oor_d   = addr_oor_c;
          end
        end else if (!wr_pend_q) begin
          state_d = S_REL;
        end
      end
      S_RD1: state_d = S_RD2;
      S_RD2: begin
        din_d   = oor_q ? 8'hFF : nv_dout;
        state_d = S_XFER;
      end
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    halt_d = state_d inside {S_HALT, S_XFER, S_RD1, S_RD2};
    wait_d = state_d inside {S_HALT, S_RD1, S_RD2};
    busy_d = (state_d != S_IDLE);
  end

  // The engine owns the nvram port only once the CPU has acknowledged the halt.
  assign engine_sel_c = state_q inside {S_XFER, S_RD1, S_RD2};
  assign nv_we   = engine_sel_c ? wr_pend_q : cpu_nv_we;
  assign nv_addr = engine_sel_c ? addr_q    : cpu_nv_addr;
  assign nv_din  = engine_sel_c ? data_q    : cpu_nv_din;

  assign cpu_halt_req     = halt_q;
  assign ioctl.ioctl_wait = wait_q;
  assign ioctl.ioctl_din  = din_q;
  assign busy             = busy_q;

`ifdef NVRAM_DIRTY_EN
  logic       dirty_q, save_q, vblank_q, vb_rise_c, cpu_wr_c;
  logic [7:0] quiet_q;

  assign vb_rise_c = vblank & ~vblank_q;
  assign cpu_wr_c  = (state_q == S_IDLE) & cpu_nv_we;

  // Quiet timer: counts vblanks since the last CPU write. save_req fires once when the count reaches the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dirty_q  <= 1'b0;
      save_q   <= 1'b0;
      vblank_q <= 1'b0;
      quiet_q  <= 8'd0;
    end else begin
      vblank_q <= vblank;
      save_q   <= 1'b0;
      if (state_q == S_REL) begin
        dirty_q <= 1'b0;
        quiet_q <= 8'd0;
      end else if (cpu_wr_c) begin
        dirty_q <= 1'b1;
        quiet_q <= 8'd0;
      end else if (dirty_q && vb_rise_c && (quiet_q != 8'(AUTOSAVE_FRAMES))) begin
        quiet_q <= quiet_q + 8'd1;
        save_q  <= ((quiet_q + 8'd1) == 8'(AUTOSAVE_FRAMES));
      end
    end
  end

  assign dirty    = dirty_q;
  assign save_req = save_q;
`else
  logic unused_autosave;
  assign unused_autosave = ^{vblank, 8'(AUTOSAVE_FRAMES)};
  assign dirty    = 1'b0;
  assign save_req = 1'b0;
`endif
endmodule

// File: tb/tb_nvram_xfer.sv
`timescale 1ns/1ps
// tb_nvram_xfer: directed and randomized checks of nvram_xfer against a behavioural NVRAM image model.
module tb_nvram_xfer;
  localparam int unsigned AF = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_halt_req, cpu_halt_ack, cpu_nv_we;
  logic [7:0] cpu_nv_addr, cpu_nv_din;
  logic       nv_we;
  logic [7:0] nv_addr, nv_din, nv_dout;
  logic       vblank, busy, dirty, save_req;

  always #5 clk = ~clk;

  nvram_xfer_if ioctl();

  nvram_xfer #(.NV_INDEX(8'd4), .AUTOSAVE_FRAMES(AF)) dut (
    .clk(clk), .rst_n(rst_n), .ioctl(ioctl),
    .cpu_halt_req(cpu_halt_req), .cpu_halt_ack(cpu_halt_ack),
    .cpu_nv_we(cpu_nv_we), .cpu_nv_addr(cpu_nv_addr), .cpu_nv_din(cpu_nv_din),
    .nv_we(nv_we), .nv_addr(nv_addr), .nv_din(nv_din), .nv_dout(nv_dout),
    .vblank(vblank), .busy(busy), .dirty(dirty), .save_req(save_req)
  );

  // 256x8 nvram with a registered, read-first output
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (nv_we) mem[nv_addr] <= nv_din;
    nv_dout <= mem[nv_addr];
  end

  // Expected NVRAM image and autosave state
  logic [7:0] ref_mem [256];
  bit         dirty_m;
  int         quiet_m;
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Open a session. The CPU model acknowledges the halt 3 clocks after it is requested.
  task automatic start_session(input bit dl, input bit ul, input logic [7:0] idx);
    ioctl.ioctl_download = dl;
    ioctl.ioctl_upload   = ul;
    ioctl.ioctl_index    = idx;
    tick();
    check("halt_req_set", 32'(cpu_halt_req), 32'd1);
    check("wait_halt",    32'(ioctl.ioctl_wait), 32'd1);
    check("busy_halt",    32'(busy), 32'd1);
    tick();
    check("wait_halt2",   32'(ioctl.ioctl_wait), 32'd1);
    tick();
    check("wait_halt3",   32'(ioctl.ioctl_wait), 32'd1);
    cpu_halt_ack = 1'b1;
    tick();
    check("wait_after_ack", 32'(ioctl.ioctl_wait), 32'd0);
    check("halt_in_xfer",   32'(cpu_halt_req), 32'd1);
  endtask

  task automatic end_session();
    ioctl.ioctl_download = 1'b0;
    ioctl.ioctl_upload   = 1'b0;
    tick();
    check("halt_rel", 32'(cpu_halt_req), 32'd0);
    check("busy_rel", 32'(busy), 32'd1);
    cpu_halt_ack = 1'b0;
    tick();
    check("busy_idle", 32'(busy), 32'd0);
    dirty_m = 1'b0;
    quiet_m = 0;
  endtask

  task automatic dl_byte(input int a, input logic [7:0] d);
    ioctl.ioctl_addr = 25'(a);
    ioctl.ioctl_dout = d;
    ioctl.ioctl_wr   = 1'b1;
    tick();
    ioctl.ioctl_wr = 1'b0;
    check("dl_we", 32'(nv_we), (a < 256) ? 32'd1 : 32'd0);
    if (a < 256) begin
      check("dl_addr", 32'(nv_addr), 32'(a));
      check("dl_din",  32'(nv_din), 32'(d));
      ref_mem[a] = d;
    end
    tick();
    check("dl_we_pulse", 32'(nv_we), 32'd0);
  endtask

  task automatic ul_byte(input int a);
    ioctl.ioctl_addr = 25'(a);
    ioctl.ioctl_rd   = 1'b1;
    tick();
    ioctl.ioctl_rd = 1'b0;
    check("ul_wait1", 32'(ioctl.ioctl_wait), 32'd1);
    tick();
    check("ul_wait2", 32'(ioctl.ioctl_wait), 32'd1);
    tick();
    check("ul_wait_end", 32'(ioctl.ioctl_wait), 32'd0);
    check("ul_din", 32'(ioctl.ioctl_din), (a < 256) ? 32'(ref_mem[a]) : 32'hFF);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_nv_we = 1'b1;
    cpu_nv_addr = a;
    cpu_nv_din = d;
    #1;
    check("cpu_pass_we", 32'(nv_we), 32'd1);
    tick();
    cpu_nv_we = 1'b0;
    ref_mem[a] = d;
    dirty_m = 1'b1;
    quiet_m = 0;
  endtask

  // One vblank pulse. The model predicts save_req from the vblank count since the last write.
  task automatic vb_pulse();
    bit exp_save;
    exp_save = 1'b0;
    if (dirty_m && quiet_m < int'(AF)) begin
      quiet_m++;
      exp_save = (quiet_m == int'(AF));
    end
    vblank = 1'b1;
    tick();
`ifdef NVRAM_DIRTY_EN
    check("save_req", 32'(save_req), 32'(exp_save));
`else
    check("save_req_off", 32'(save_req), 32'd0);
`endif
    vblank = 1'b0;
    tick();
    check("save_req_low", 32'(save_req), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    dirty_m = 1'b0;
    quiet_m = 0;
    ioctl.ioctl_download = 1'b0; ioctl.ioctl_upload = 1'b0; ioctl.ioctl_index = 8'd0;
    ioctl.ioctl_addr = '0; ioctl.ioctl_wr = 1'b0; ioctl.ioctl_dout = 8'h00; ioctl.ioctl_rd = 1'b0;
    cpu_halt_ack = 1'b0; cpu_nv_we = 1'b0; cpu_nv_addr = 8'h00; cpu_nv_din = 8'h00; vblank = 1'b0;

    tick(); tick();
    rst_n = 1'b1;
    check("rst_halt", 32'(cpu_halt_req), 32'd0);
    check("rst_wait", 32'(ioctl.ioctl_wait), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_din",  32'(ioctl.ioctl_din), 32'h00);
    check("rst_dirty", 32'(dirty), 32'd0);
    check("rst_save",  32'(save_req), 32'd0);

    // Full image download of addr^5A, with one out-of-range byte that must be ignored
    start_session(1'b1, 1'b0, 8'd4);
    for (int a = 0; a < 256; a++) dl_byte(a, 8'(a) ^ 8'h5A);
    dl_byte(300, 8'h99);
    end_session();
    cpu_nv_addr = 8'h00;
    tick();
    check("cpu_readback0", 32'(nv_dout), 32'h5A);

    // Full image upload. The last read is out of range, so ioctl_din ends at FF.
    start_session(1'b0, 1'b1, 8'd4);
    for (int a = 0; a < 256; a++) ul_byte(a);
    ul_byte(300);
    check("ul_oor_ff", 32'(ioctl.ioctl_din), 32'hFF);

    // Reset while the engine is in RD1
    ioctl.ioctl_addr = 25'd5;
    ioctl.ioctl_rd = 1'b1;
    tick();
    ioctl.ioctl_rd = 1'b0;
    check("rd1_wait", 32'(ioctl.ioctl_wait), 32'd1);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mrst_halt", 32'(cpu_halt_req), 32'd0);
      check("mrst_wait", 32'(ioctl.ioctl_wait), 32'd0);
      check("mrst_din",  32'(ioctl.ioctl_din), 32'h00);
      check("mrst_busy", 32'(busy), 32'd0);
    end
    ioctl.ioctl_upload = 1'b0;
    cpu_halt_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    check("mrst_idle", 32'(busy), 32'd0);

    // Foreign index: the session is ignored, and the CPU write passes through.
    ioctl.ioctl_download = 1'b1;
    ioctl.ioctl_index = 8'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idx2_halt", 32'(cpu_halt_req), 32'd0);
      check("idx2_busy", 32'(busy), 32'd0);
    end
    cpu_write(8'd10, 8'h33);
    ioctl.ioctl_download = 1'b0;
    tick();
    check("idx2_mem10", 32'(mem[10]), 32'h33);

    // A CPU write during XFER is blocked. Download takes priority over a simultaneous upload request.
    start_session(1'b1, 1'b1, 8'd4);
    cpu_nv_we = 1'b1; cpu_nv_addr = 8'd7; cpu_nv_din = 8'hEE;
    #1;
    check("blocked_we", 32'(nv_we), 32'd0);
    tick();
    cpu_nv_we = 1'b0;
    ioctl.ioctl_rd = 1'b1;
    dl_byte(20, 8'h77);
    ioctl.ioctl_rd = 1'b0;
    check("both_no_rd_wait", 32'(ioctl.ioctl_wait), 32'd0);
    end_session();
    check("blocked_mem7", 32'(mem[7]), 32'(ref_mem[7]));

    // Randomized download then upload, both including out-of-range addresses
    start_session(1'b1, 1'b0, 8'd4);
    for (int i = 0; i < 40; i++) dl_byte(int'($urandom_range(0, 399)), 8'($urandom));
    end_session();
    start_session(1'b0, 1'b1, 8'd4);
    for (int i = 0; i < 40; i++) ul_byte(int'($urandom_range(0, 399)));
    end_session();

    // Autosave quiet timer
    cpu_write(8'd12, 8'h11);
`ifdef NVRAM_DIRTY_EN
    check("dirty_set", 32'(dirty), 32'd1);
`else
    check("dirty_off", 32'(dirty), 32'd0);
`endif
    vb_pulse(); vb_pulse();
    cpu_write(8'd13, 8'h22);
    vb_pulse(); vb_pulse(); vb_pulse(); vb_pulse();
    start_session(1'b0, 1'b1, 8'd4);
    ul_byte(12);
    ul_byte(13);
    end_session();
    tick();
    check("dirty_clear", 32'(dirty), 32'd0);

    for (int a = 0; a < 256; a++) check("final_image", 32'(mem[a]), 32'(ref_mem[a]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
